// File: rtl/four_bit_restoring_divider.sv
// Four-bit unsigned restoring divider, one quotient bit per clock.
// Divide-by-zero bypasses the iteration and reports a saturated quotient.
module four_bit_restoring_divider (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [3:0] Dividend,
   input  logic [3:0] Divisor,
   output logic       busy,
   output logic       done,
   output logic [3:0] Quotient,
   output logic [3:0] Remainder,
   output logic       div_by_zero
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t     r_state;
   state_t     w_state_nxt;

   logic [3:0] r_rem;
   logic [3:0] r_quo;
   logic [3:0] r_dvs;
   logic [2:0] r_cnt;

   logic [3:0] r_quot;
   logic [3:0] r_remd;
   logic       r_dbz;

   logic [4:0] w_shr;
   logic [4:0] w_trial;
   logic [3:0] w_rem_nxt;
   logic [3:0] w_quo_nxt;

   logic       w_accept;
   logic       w_zero;
   logic       w_last;

   // One restoring step: shift {R,Q} left, try subtracting the divisor.
   always_comb begin
      w_shr   = {r_rem, r_quo[3]};
      w_trial = w_shr - {1'b0, r_dvs};
      if (w_trial[4]) begin
         w_rem_nxt = w_shr[3:0];
         w_quo_nxt = {r_quo[2:0], 1'b0};
      end else begin
         w_rem_nxt = w_trial[3:0];
         w_quo_nxt = {r_quo[2:0], 1'b1};
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_zero      = 1'b0;
      w_last      = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (start) begin
               w_accept = 1'b1;
               if (Divisor == 4'd0) begin
                  w_zero      = 1'b1;
                  w_state_nxt = DONE;
               end else begin
                  w_state_nxt = CALC;
               end
            end
         end
         CALC: begin
            if (r_cnt == 3'd1) begin
               w_last      = 1'b1;
               w_state_nxt = DONE;
            end
         end
         DONE: begin
            w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_rem  <= 4'd0;
         r_quo  <= 4'd0;
         r_dvs  <= 4'd0;
         r_cnt  <= 3'd0;
         r_quot <= 4'd0;
         r_remd <= 4'd0;
         r_dbz  <= 1'b0;
      end else begin
         if (w_accept && !w_zero) begin
            r_rem <= 4'd0;
            r_quo <= Dividend;
            r_dvs <= Divisor;
            r_cnt <= 3'd4;
         end else if (r_state == CALC) begin
            r_rem <= w_rem_nxt;
            r_quo <= w_quo_nxt;
            r_cnt <= r_cnt - 3'd1;
         end
         // Results only move on entry to DONE and hold otherwise.
         if (w_zero) begin
            r_quot <= 4'hF;
            r_remd <= Dividend;
            r_dbz  <= 1'b1;
         end else if (w_last) begin
            r_quot <= w_quo_nxt;
            r_remd <= w_rem_nxt;
            r_dbz  <= 1'b0;
         end
      end
   end

   assign busy        = (r_state == CALC);
   assign done        = (r_state == DONE);
   assign Quotient    = r_quot;
   assign Remainder   = r_remd;
   assign div_by_zero = r_dbz;

endmodule
